// File: rtl/factor_pkg.sv
// Shared sizing and state encoding for the factor search controller.
package factor_pkg;
  parameter int W = 5;
  localparam int MAXF = 2**W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fs_state_t;
endpackage

// File: rtl/factor_check.sv
// Combinational multiply-compare of one candidate pair against the target.
// The product is formed at full 2W width so it can never wrap past the target.
module factor_check #(
  parameter int W = factor_pkg::W
) (
  input  logic [W-1:0]   c1,
  input  logic [W-1:0]   c2,
  input  logic [2*W-1:0] a_q,
  output logic           eq,
  output logic           gt
);
  logic [2*W-1:0] p;

  assign p  = {{W{1'b0}}, c1} * {{W{1'b0}}, c2};
  assign eq = (p == a_q);
  assign gt = (p > a_q);
endmodule

// File: rtl/factor_search_ctrl.sv
// Walks candidate pairs (c1 <= c2) one per cycle through factor_check until the
// target is matched or no pair with c1 <= c2 can reach it.
module factor_search_ctrl #(
  parameter int W = factor_pkg::W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [2*W-1:0] a,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [W-1:0]   f1,
  output logic [W-1:0]   f2,
  output logic [2*W-1:0] iters
);
  import factor_pkg::*;

  localparam logic [W-1:0]   C_MAX  = '1;
  localparam logic [W-1:0]   C_ONE  = W'(1);
  localparam logic [W-1:0]   C_TWO  = W'(2);
  localparam logic [2*W-1:0] IT_MAX = '1;
  localparam logic [2*W-1:0] IT_ONE = (2*W)'(1);

  fs_state_t      state_q, state_d;
  logic [W-1:0]   c1_q, c1_d, c2_q, c2_d;
  logic [W-1:0]   f1_q, f1_d, f2_q, f2_d;
  logic [2*W-1:0] a_q, a_d, iters_q, iters_d;
  logic           found_q, found_d;
  logic           eq, gt;
  logic           row_end;

  factor_check #(.W(W)) u_check (
    .c1  (c1_q),
    .c2  (c2_q),
    .a_q (a_q),
    .eq  (eq),
    .gt  (gt)
  );

  // A row ends when the product overshoots or c2 hits the top of its range.
  assign row_end = gt || (c2_q == C_MAX);

  always_comb begin
    state_d = state_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    a_d     = a_q;
    iters_d = iters_q;
    found_d = found_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    case (state_q)
      SEARCH: begin
        iters_d = (iters_q == IT_MAX) ? iters_q : iters_q + IT_ONE;
        if (abort) begin
          state_d = IDLE;
          found_d = 1'b0;
          f1_d    = '0;
          f2_d    = '0;
        end else if (eq) begin
          state_d = DONE;
          found_d = 1'b1;
          f1_d    = c1_q;
          f2_d    = c2_q;
        end else if ((gt && (c2_q == c1_q)) || (row_end && (c1_q == C_MAX))) begin
          state_d = DONE;
          found_d = 1'b0;
          f1_d    = '0;
          f2_d    = '0;
        end else if (row_end) begin
          c1_d = c1_q + C_ONE;
          c2_d = c1_q + C_ONE;
        end else begin
          c2_d = c2_q + C_ONE;
        end
      end
      default: begin
        if (start) begin
          state_d = SEARCH;
          a_d     = a;
          c1_d    = C_TWO;
          c2_d    = C_TWO;
          iters_d = '0;
          found_d = 1'b0;
          f1_d    = '0;
          f2_d    = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c1_q    <= '0;
      c2_q    <= '0;
      a_q     <= '0;
      iters_q <= '0;
      found_q <= 1'b0;
      f1_q    <= '0;
      f2_q    <= '0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      a_q     <= a_d;
      iters_q <= iters_d;
      found_q <= found_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
    end
  end

  assign busy  = (state_q == SEARCH);
  assign done  = (state_q == DONE);
  assign found = found_q;
  assign f1    = f1_q;
  assign f2    = f2_q;
  assign iters = iters_q;
endmodule

// File: tb/tb_factor_search_ctrl.sv
// Randomized and directed bench for factor_search_ctrl against a pair-walking reference model.
module tb_factor_search_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] a = '0;
  logic       busy, done, found;
  logic [4:0] f1, f2;
  logic [9:0] iters;

  int n_chk = 0;
  int n_fail = 0;

  factor_search_ctrl #(.W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .found (found),
    .f1    (f1),
    .f2    (f2),
    .iters (iters)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] k;
    logic        fnd;
    logic [4:0]  f1;
    logic [4:0]  f2;
  } res_t;

  // Visit pairs in search order; k counts pairs visited up to and including the last one.
  function automatic res_t search(input int av);
    res_t r;
    r = '0;
    for (int x = 2; x <= 31; x++) begin
      for (int y = x; y <= 31; y++) begin
        r.k = r.k + 16'd1;
        if (x * y == av) begin
          r.fnd = 1'b1;
          r.f1  = x[4:0];
          r.f2  = y[4:0];
          return r;
        end
        if (x * y > av) begin
          if (y == x) return r;
          break;
        end
      end
    end
    return r;
  endfunction

  res_t sr, m_res = '0;
  always_comb sr = search(int'(a));

  logic       m_busy = 1'b0, m_done = 1'b0, m_found = 1'b0;
  logic [4:0] m_f1 = '0, m_f2 = '0;
  logic [9:0] m_iters = '0;
  int         m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_found <= 1'b0;
      m_f1    <= '0;
      m_f2    <= '0;
      m_iters <= '0;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_iters <= m_iters + 10'd1;
        if (abort) begin
          m_busy  <= 1'b0;
          m_found <= 1'b0;
          m_f1    <= '0;
          m_f2    <= '0;
        end else if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_found <= m_res.fnd;
          m_f1    <= m_res.f1;
          m_f2    <= m_res.f2;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_busy  <= 1'b1;
        m_res   <= sr;
        m_left  <= int'(sr.k);
        m_iters <= '0;
        m_found <= 1'b0;
        m_f1    <= '0;
        m_f2    <= '0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("found", 32'(found), 32'(m_found));
    check("f1", 32'(f1), 32'(m_f1));
    check("f2", 32'(f2), 32'(m_f2));
    check("iters", 32'(iters), 32'(m_iters));
  end

  task automatic go(input logic [9:0] av);
    @(posedge clk);
    #1 start = 1'b1;
    a = av;
    @(posedge clk);
    #1 start = 1'b0;
    a = 10'($urandom_range(0, 1023));
  endtask

  // Returns the number of cycles after the accepting edge up to and including the done cycle.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (done) return;
    end
    check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_expect(input string nm, input logic [9:0] av, input int cyc_exp,
                            input logic fnd, input logic [4:0] e1, input logic [4:0] e2,
                            input logic [9:0] it);
    int cyc;
    go(av);
    wait_done(cyc);
    if (cyc_exp > 0) check({nm, "_latency"}, 32'(cyc), 32'(cyc_exp));
    check({nm, "_found"}, 32'(found), 32'(fnd));
    check({nm, "_f1"}, 32'(f1), 32'(e1));
    check({nm, "_f2"}, 32'(f2), 32'(e2));
    check({nm, "_iters"}, 32'(iters), 32'(it));
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_iters", 32'(iters), 32'(0));
    rst_n = 1'b1;

    run_expect("a6", 10'd6, 3, 1'b1, 5'd2, 5'd3, 10'd2);
    // Restart in the DONE cycle.
    start = 1'b1;
    a = 10'd6;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", 32'(cyc), 32'(3));
    check("b2b_f1", 32'(f1), 32'(2));
    check("b2b_f2", 32'(f2), 32'(3));

    run_expect("a7", 10'd7, 5, 1'b0, 5'd0, 5'd0, 10'd4);
    run_expect("a35", 10'd35, 37, 1'b1, 5'd5, 5'd7, 10'd36);
    run_expect("a961", 10'd961, 0, 1'b1, 5'd31, 5'd31, 10'(search(961).k));
    run_expect("a1023", 10'd1023, 0, 1'b0, 5'd0, 5'd0, 10'(search(1023).k));
    repeat (5) begin
      @(negedge clk);
      check("a1023_single_done", 32'(done), 32'(0));
    end
    run_expect("a0", 10'd0, 2, 1'b0, 5'd0, 5'd0, 10'd1);
    run_expect("a3", 10'd3, 2, 1'b0, 5'd0, 5'd0, 10'd1);

    go(10'd35);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_found", 32'(found), 32'(0));
    check("abort_iters", 32'(iters), 32'(10));
    repeat (5) @(negedge clk);

    go(10'd35);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    a = 10'd6;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    check("ignore_start_f1", 32'(f1), 32'(5));
    check("ignore_start_f2", 32'(f2), 32'(7));
    check("ignore_start_iters", 32'(iters), 32'(36));

    go(10'd35);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_iters", 32'(iters), 32'(0));
    check("arst_found", 32'(found), 32'(0));
    check("arst_f1", 32'(f1), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 40; t++) begin
      logic [9:0] av;
      case ($urandom_range(0, 2))
        0: av = 10'($urandom_range(0, 1023));
        1: av = 10'($urandom_range(2, 31) * $urandom_range(2, 31));
        default: av = 10'($urandom_range(0, 40));
      endcase
      go(av);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1 if (busy) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
      wait_idle();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/factor_search_ctrl.md
# factor_search_ctrl

Sequential controller that finds a nontrivial factorization of a 2W-bit composite `a` into two W-bit factors `f1 * f2 == a` with `2 <= f1 <= f2`. It walks candidate pairs one per cycle through a combinational multiply-compare datapath of the same shape as the team's factorization check formulas. It serves as the reference search engine and cross-checker for synthesized factorization circuits: the bench compares its found/not-found verdict against the synthesized formula's verdict.

## Interface
- `W`, default 5: factor width in bits; product and target width is 2W.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a search on `a`; accepted only when `busy == 0`.
- `abort`  in  1: cancel a running search.
- `a`  in  2W: target value; sampled only on an accepted `start`.
- `busy`  out  1: high while in SEARCH.
- `done`  out  1: one-cycle pulse when a search completes (not pulsed on abort).
- `found`  out  1: last completed search found a factorization.
- `f1`  out  W: smaller factor when `found`, else 0.
- `f2`  out  W: larger factor when `found`, else 0.
- `iters`  out  2W: number of SEARCH cycles spent in the current or last search.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE or DONE with `start`:
  - latch `a_q <= a`;
  - candidates `c1 <= 2`, `c2 <= 2`;
  - `iters <= 0`, `found <= 0`;
  - go to SEARCH.
- SEARCH evaluates `p = c1 * c2`. `p` is a full 2W-bit unsigned product with no truncation, compared unsigned against `a_q`. Rules apply in priority order:
  1. `abort`: go to IDLE. `found`, `f1`, `f2` are cleared and `done` is not pulsed.
  2. `p == a_q`: `found <= 1`, `f1 <= c1`, `f2 <= c2`; go to DONE.
  3. `p > a_q` and `c2 == c1`: search is exhausted. `found <= 0`, `f1 <= 0`, `f2 <= 0`; go to DONE.
  4. `p > a_q` or `c2 == 2^W-1`:
     - if `c1 == 2^W-1`, search is exhausted (handled as in rule 3);
     - otherwise `c1 <= c1+1`, `c2 <= c1+1`.
  5. Otherwise `c2 <= c2+1`.
- Every SEARCH cycle, including the terminating one, increments `iters`. `iters` saturates at `2^2W-1`, which is unreachable for W=5.
- DONE lasts exactly one cycle with `done = 1`, then returns to IDLE. A `start` during DONE is accepted and takes priority over the return to IDLE.
- `start` during SEARCH is ignored. `abort` outside SEARCH is ignored.
- Changes to `a` during SEARCH have no effect.
- `a < 4` terminates in the first SEARCH cycle with `found = 0`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `found` = 0; `f1`, `f2` = 0; `iters` = 0; `c1`, `c2`, `a_q` = 0.
- Reset asserted mid-search returns to IDLE immediately, with no `done` pulse.
- `start` accepted at edge N: `busy = 1` from cycle N+1.
- A search using k SEARCH cycles:
  - `done` pulses in cycle N+1+k;
  - `busy` falls in the same cycle;
  - `found`, `f1`, `f2`, `iters` are valid from that cycle and held until the next accepted `start`.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Worst case (W=5) is bounded by 465 pair visits plus early-exit cycles.

## Structure
- `factor_pkg`: holds
  - parameter `W`;
  - `localparam MAXF = 2**W-1`;
  - state enum `fs_state_t {IDLE, SEARCH, DONE}`.
- Sub-module `factor_check`: purely combinational.
  - Inputs `c1`, `c2` (W bits) and `a_q` (2W bits).
  - Outputs `eq` (`c1*c2 == a_q`) and `gt` (`c1*c2 > a_q`).
  - Its multiply-compare is the datapath being sequenced. The controller instantiates exactly one.

## Test plan
- `a=6`, start → `iters=2`, `done` at start+3, `found=1`, `f1=2`, `f2=3`.
- `a=7` (prime) → visits (2,2),(2,3),(2,4),(3,3); `iters=4`, `found=0`, `f1=f2=0`.
- `a=35` → `found=1`, `f1=5`, `f2=7`, `iters=36`. `a=961` → `found=1`, `f1=31`, `f2=31`.
- `a=1023` (only factor pairs with one factor > 31) → `found=0`, single `done` pulse. `a=0` and `a=3` → `found=0`, `iters=1`.
- Mid-search events during `a=35`:
  - `abort` at SEARCH cycle 10 → IDLE next cycle, no `done`, `found=0`;
  - `start` with a new `a` while busy → ignored;
  - `rst_n` low mid-search → all outputs 0 asynchronously.
- `start` asserted in the DONE cycle with `a=6` → back-to-back search, `busy` the next cycle, second `done` 3 cycles later with `f1=2`, `f2=3`.
